// File: rtl/lsu_aligner.sv
// lsu_aligner: load/store alignment unit between the memory stage and a synchronous-read data BRAM.
// Define MISALIGN_SPLIT_EN to execute misaligned accesses (two beats when crossing a bus word).
module lsu_aligner #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              err_misalign,
    output logic              err_funct
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
`ifdef MISALIGN_SPLIT_EN
        BEAT1 = 2'd2,
`endif
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              req_store_q;
    logic [2:0]        req_funct3_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [4:0]        req_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
`ifdef MISALIGN_SPLIT_EN
    logic [XLEN-1:0]   rdata0_q;
    logic              split;
`endif

    logic              accept, funct_bad, misalign_bad;
    logic [OFFW-1:0]   off;
    int                size;
    logic [NB-1:0]     size_mask;
    logic [2*NB-1:0]   lane_wide;
    logic [2*XLEN-1:0] data_wide;
    logic [ADDR_W-1:0] base_addr, cur_addr;
    logic [XLEN-1:0]   cur_wdata;
    logic [2*XLEN-1:0] load_wide;
    logic [XLEN-1:0]   shifted, load_ext;
    logic              sign_bit;

    // Request legality is judged on the raw inputs so a rejected access never leaves IDLE.
    always_comb begin
        accept    = req_valid && (state_q == IDLE);
        funct_bad = (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
        if (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110))
            funct_bad = 1'b1;
`ifdef MISALIGN_SPLIT_EN
        misalign_bad = 1'b0;
`else
        misalign_bad = (req_addr[2:0] & ((3'b001 << req_funct3[1:0]) - 3'b001)) != 3'b000;
`endif
    end

    // Both beats come from one double-width shift: the low half is beat 0, the high half beat 1.
    always_comb begin
        off  = req_addr_q[OFFW-1:0];
        size = 1 << req_funct3_q[1:0];
        for (int i = 0; i < NB; i++)
            size_mask[i] = (i < size);
        lane_wide = {{NB{1'b0}}, size_mask} << off;
        data_wide = {{XLEN{1'b0}}, req_wdata_q} << {off, 3'b000};
        base_addr = {req_addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
`ifdef MISALIGN_SPLIT_EN
        split = (int'(off) + size) > NB;
`endif
    end

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_wen   = '0;
        cur_addr  = base_addr;
        cur_wdata = XLEN'(data_wide);
        case (state_q)
            IDLE: begin
                if (accept && !funct_bad && !misalign_bad)
                    state_d = BEAT0;
            end
            BEAT0: begin
                mem_en = 1'b1;
                if (req_store_q)
                    mem_wen = NB'(lane_wide);
                state_d = req_store_q ? IDLE : DRAIN;
`ifdef MISALIGN_SPLIT_EN
                if (split)
                    state_d = BEAT1;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            BEAT1: begin
                mem_en    = 1'b1;
                cur_addr  = base_addr + ADDR_W'(NB);
                cur_wdata = data_wide[2*XLEN-1:XLEN];
                if (req_store_q)
                    mem_wen = lane_wide[2*NB-1:NB];
                state_d = req_store_q ? IDLE : DRAIN;
            end
`endif
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign mem_addr  = mem_en ? cur_addr : mem_addr_q;
    assign mem_wdata = mem_en ? cur_wdata : mem_wdata_q;

    // In DRAIN the current read data is the last beat; for a split load it is the upper word.
    always_comb begin
`ifdef MISALIGN_SPLIT_EN
        load_wide = split ? {mem_rdata, rdata0_q} : {{XLEN{1'b0}}, mem_rdata};
`else
        load_wide = {{XLEN{1'b0}}, mem_rdata};
`endif
        shifted  = XLEN'(load_wide >> {off, 3'b000});
        sign_bit = shifted[8*size-1] & ~req_funct3_q[2];
        load_ext = shifted;
        for (int i = 0; i < XLEN; i++)
            if (i >= 8*size)
                load_ext[i] = sign_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_store_q  <= 1'b0;
            req_funct3_q <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_rd_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_rd       <= '0;
            err_funct    <= 1'b0;
            err_misalign <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            rdata0_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            err_funct    <= accept && funct_bad;
            err_misalign <= accept && !funct_bad && misalign_bad;
            rsp_valid    <= (state_q == DRAIN);
            if (accept && !funct_bad && !misalign_bad) begin
                req_store_q  <= req_store;
                req_funct3_q <= req_funct3;
                req_addr_q   <= req_addr;
                req_wdata_q  <= req_wdata;
                req_rd_q     <= req_rd;
            end
            if (mem_en) begin
                mem_addr_q  <= cur_addr;
                mem_wdata_q <= cur_wdata;
            end
            if (state_q == DRAIN) begin
                rsp_data <= load_ext;
                rsp_rd   <= req_rd_q;
            end
`ifdef MISALIGN_SPLIT_EN
            if (state_q == BEAT1)
                rdata0_q <= mem_rdata;
`endif
        end
    end
endmodule

// File: tb/tb_lsu_aligner.sv
// tb_lsu_aligner: table-driven and randomized checks of lsu_aligner (XLEN=32) against a byte-level model.
module tb_lsu_aligner;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int NB     = 4;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_data;
    logic [4:0]        rsp_rd;
    logic              err_misalign;
    logic              err_funct;

    lsu_aligner #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .err_misalign(err_misalign), .err_funct(err_funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [31:0] next_rdata;

    typedef struct {
        logic        store;
        logic [2:0]  f;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        exp_errf;
        logic        exp_errm;
        logic        exp_rv;
        logic [31:0] exp_rsp;
        logic [31:0] exp_addr0;
        logic [3:0]  exp_wen0;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic store, input logic [2:0] f, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic errf, input logic errm, input logic rv,
                                input logic [31:0] rsp, input logic [31:0] addr0, input logic [3:0] wen0);
        vec_t v;
        v.store = store; v.f = f; v.addr = addr; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
        v.exp_errf = errf; v.exp_errm = errm; v.exp_rv = rv; v.exp_rsp = rsp;
        v.exp_addr0 = addr0; v.exp_wen0 = wen0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Read data changes just after the edge so it is stable for the whole following cycle.
    task automatic stepCycle(input logic junk_req);
        @(posedge clk);
        #1;
        mem_rdata  = next_rdata;
        next_rdata = $urandom;
        req_valid  = junk_req;
        if (junk_req) begin
            req_store  = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_rd     = 5'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic idleCycle();
        stepCycle(1'b0);
        checkOutput("idle_mem_en", mem_en, 0);
        checkOutput("idle_rsp_valid", rsp_valid, 0);
        checkOutput("idle_err_funct", err_funct, 0);
        checkOutput("idle_err_misalign", err_misalign, 0);
        checkOutput("idle_req_ready", req_ready, 1);
        checkOutput("idle_mem_addr", mem_addr, last_addr);
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the cycle it is ready again.
    task automatic applyStimulus(input logic store, input logic [2:0] f, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input logic [31:0] rd0, input logic [31:0] rd1,
                                 output logic [31:0] got_rsp, output logic [31:0] got_addr0,
                                 output logic [3:0] got_wen0, output logic got_errf, output logic got_errm);
        int          size, off, nbeats, done, bi;
        bit          legal, errf, errm, go, beat, exp_rv;
        logic [31:0] baddr[2];
        logic [3:0]  bwen[2];
        logic [31:0] bdata[2];
        logic [31:0] rdat[2];
        logic [31:0] exp_rsp;

        size   = 1 << f[1:0];
        legal  = !(f == 3'b111 || f == 3'b011 || f == 3'b110 || (store && f >= 3'b100));
        errf   = !legal;
        errm   = legal && !SPLIT && ((addr % size) != 0);
        go     = !errf && !errm;
        off    = int'(addr % NB);
        nbeats = (off + size > NB) ? 2 : 1;
        baddr[0] = addr - 32'(off);
        baddr[1] = baddr[0] + NB;
        bwen[0] = '0; bwen[1] = '0; bdata[0] = '0; bdata[1] = '0;
        rdat[0] = rd0; rdat[1] = rd1;
        for (int k = 0; k < NB; k++) begin
            int pos = off + k;
            bdata[pos / NB][8*(pos % NB) +: 8] = wdata[8*k +: 8];
            if (store && k < size)
                bwen[pos / NB][pos % NB] = 1'b1;
        end
        exp_rsp = '0;
        if (go && !store) begin
            for (int k = 0; k < size; k++) begin
                int pos = off + k;
                exp_rsp[8*k +: 8] = rdat[pos / NB][8*(pos % NB) +: 8];
            end
            if (!f[2] && exp_rsp[8*size-1])
                for (int k = size; k < NB; k++)
                    exp_rsp[8*k +: 8] = 8'hFF;
        end
        done = !go ? 1 : (store ? nbeats + 1 : nbeats + 2);

        got_rsp = '0; got_addr0 = '0; got_wen0 = '0; got_errf = 1'b0; got_errm = 1'b0;
        checkOutput("ready_at_accept", req_ready, 1);
        req_valid  = 1'b1;
        req_store  = store;
        req_funct3 = f;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        for (int c = 1; c <= done; c++) begin
            stepCycle(c < done);
            beat = go && (c <= nbeats);
            bi   = beat ? c - 1 : 0;
            if (beat) begin
                last_addr  = baddr[bi];
                last_wdata = bdata[bi];
            end
            exp_rv = go && !store && (c == nbeats + 2);
            checkOutput("mem_en", mem_en, beat);
            checkOutput("mem_wen", mem_wen, beat ? bwen[bi] : 4'b0000);
            checkOutput("mem_addr", mem_addr, last_addr);
            checkOutput("mem_wdata", mem_wdata, last_wdata);
            checkOutput("err_funct", err_funct, errf && c == 1);
            checkOutput("err_misalign", err_misalign, errm && c == 1);
            checkOutput("req_ready", req_ready, c == done);
            checkOutput("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                checkOutput("rsp_data", rsp_data, exp_rsp);
                checkOutput("rsp_rd", rsp_rd, rd);
                got_rsp = rsp_data;
            end
            if (c == 1) begin
                got_addr0 = mem_addr;
                got_wen0  = mem_wen;
                got_errf  = err_funct;
                got_errm  = err_misalign;
            end
            if (beat && !store)
                next_rdata = rdat[bi];
        end
    endtask

    initial begin
        logic [31:0] g_rsp, g_a0, a;
        logic [3:0]  g_w0;
        logic        g_ef, g_em;

        rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0; mem_rdata = '0;
        next_rdata = '0; last_addr = '0; last_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_wen", mem_wen, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_rd", rsp_rd, 0);
        checkOutput("rst_err_funct", err_funct, 0);
        checkOutput("rst_err_misalign", err_misalign, 0);

        vecs.push_back(mk(1, 3'b000, 32'h103, 32'hAB, 0, 0, 0, 0, 0, 0, 32'h100, 4'b1000));
        vecs.push_back(mk(0, 3'b001, 32'h102, 32'h5555, 32'h8001_1234, 0, 0, 0, 1, 32'hFFFF_8001, 32'h100, 4'b0000));
        vecs.push_back(mk(0, 3'b101, 32'h102, 32'h5555, 32'h8001_1234, 0, 0, 0, 1, 32'h0000_8001, 32'h100, 4'b0000));
        vecs.push_back(mk(0, 3'b011, 32'h40, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 32'h40, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b111, 32'h40, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b110, 32'h40, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h1, 0, 32'h0000_8000, 0, 0, 0, 1, 32'hFFFF_FF80, 32'h0, 4'b0000));
        vecs.push_back(mk(0, 3'b100, 32'h1, 0, 32'h0000_8000, 0, 0, 0, 1, 32'h0000_0080, 32'h0, 4'b0000));
        vecs.push_back(mk(0, 3'b010, 32'h1000, 0, 32'hCAFE_BABE, 0, 0, 0, 1, 32'hCAFE_BABE, 32'h1000, 4'b0000));
        vecs.push_back(mk(1, 3'b001, 32'h2, 32'h1234, 0, 0, 0, 0, 0, 0, 32'h0, 4'b1100));
        vecs.push_back(mk(1, 3'b010, 32'h7C, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 32'h7C, 4'b1111));
        vecs.push_back(mk(1, 3'b010, 32'h1FE, 32'h1122_3344, 0, 0, 0, !SPLIT, 0, 0, 32'h1FC, 4'b1100));
        vecs.push_back(mk(0, 3'b010, 32'h3, 0, 32'hDDCC_BBAA, 32'h4433_2211, 0, !SPLIT, SPLIT, 32'h3322_11DD, 32'h0, 4'b0000));
        vecs.push_back(mk(0, 3'b010, 32'h2, 0, 32'hDDCC_BBAA, 32'h4433_2211, 0, !SPLIT, SPLIT, 32'h2211_DDCC, 32'h0, 4'b0000));
        vecs.push_back(mk(1, 3'b001, 32'hFFFF_FFFF, 32'hBEEF, 0, 0, 0, !SPLIT, 0, 0, 32'hFFFF_FFFC, 4'b1000));
        vecs.push_back(mk(0, 3'b001, 32'h3, 0, 32'hDDCC_BBAA, 32'h4433_2211, 0, !SPLIT, SPLIT, 32'h0000_11DD, 32'h0, 4'b0000));
        vecs.push_back(mk(0, 3'b001, 32'h1, 0, 32'hDDCC_BBAA, 0, 0, !SPLIT, SPLIT, 32'hFFFF_CCBB, 32'h0, 4'b0000));

        $display("[TB] directed table, back-to-back");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].store, vecs[i].f, vecs[i].addr, vecs[i].wdata, 5'(i + 1),
                          vecs[i].rd0, vecs[i].rd1, g_rsp, g_a0, g_w0, g_ef, g_em);
            checkOutput($sformatf("tbl%0d_err_funct", i), g_ef, vecs[i].exp_errf);
            checkOutput($sformatf("tbl%0d_err_misalign", i), g_em, vecs[i].exp_errm);
            if (!vecs[i].exp_errf && !vecs[i].exp_errm) begin
                checkOutput($sformatf("tbl%0d_addr0", i), g_a0, vecs[i].exp_addr0);
                checkOutput($sformatf("tbl%0d_wen0", i), g_w0, vecs[i].exp_wen0);
            end
            if (vecs[i].exp_rv)
                checkOutput($sformatf("tbl%0d_rsp", i), g_rsp, vecs[i].exp_rsp);
        end

        $display("[TB] reset during a load");
        idleCycle();
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = SPLIT ? 32'h203 : 32'h200; req_wdata = $urandom; req_rd = 5'd9;
        stepCycle(1'b0);
        stepCycle(1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        last_addr = '0;
        last_wdata = '0;
        checkOutput("rstmid_rsp_valid", rsp_valid, 0);
        checkOutput("rstmid_req_ready", req_ready, 1);
        checkOutput("rstmid_mem_en", mem_en, 0);
        checkOutput("rstmid_mem_addr", mem_addr, 0);
        checkOutput("rstmid_mem_wdata", mem_wdata, 0);
        repeat (2) idleCycle();

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 5) == 0)
                idleCycle();
            a = $urandom;
            if ($urandom_range(0, 3) == 0)
                a = 32'hFFFF_FFF8 | (a & 32'h7);
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                          5'($urandom), $urandom, $urandom, g_rsp, g_a0, g_w0, g_ef, g_em);
        end
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lsu_aligner.md
# lsu_aligner

Parametrised load/store alignment unit between the core's memory stage and a synchronous-read data BRAM. It is the sequential successor to the combinational load/store byte-lane decoder and supports XLEN of 32 or 64. It generates per-lane write enables and shifted store data, and sign- or zero-extends load data. Accesses that cross a bus-word boundary are split into two bus beats and merged, rather than being zeroed.

## Interface
- XLEN, 32: data/bus width; legal values 32, 64. NB = XLEN/8 byte lanes.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV funct3: LB/SB 000, LH/SH 001, LW/SW 010, LD/SD 011 (XLEN=64 only), LBU 100, LHU 101, LWU 110 (XLEN=64 only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- req_rd  in  5  destination tag, returned with load response.
- mem_en  out  1  bus beat issued this cycle.
- mem_addr  out  ADDR_W  bus-word-aligned address (low log2(NB) bits 0).
- mem_wen  out  NB  per-lane write enable; all 0 for loads.
- mem_wdata  out  XLEN  lane-positioned store data.
- mem_rdata  in  XLEN  read data, valid the cycle after a mem_en load beat.
- rsp_valid  out  1  one-cycle load-result pulse.
- rsp_data  out  XLEN  extended load result.
- rsp_rd  out  5  tag of the response.
- err_misalign  out  1  one-cycle pulse: misaligned access rejected.
- err_funct  out  1  one-cycle pulse: illegal funct3 for XLEN rejected.

## Operation
- Definitions:
  - size = 1, 2, 4 or 8 bytes.
  - off = req_addr mod NB.
  - split when off + size > NB.
- On accept (req_valid && req_ready), the request is registered in full.
- States: IDLE, BEAT0, BEAT1, DRAIN.
- Transitions:
  - IDLE → BEAT0 on accept.
  - BEAT0 → BEAT1 if split; else → DRAIN for loads, → IDLE for stores.
  - BEAT1 → DRAIN for loads, → IDLE for stores.
  - DRAIN → IDLE.
- BEAT0 drives:
  - mem_addr = addr with low bits cleared.
  - mem_wen = (size-mask << off), truncated to NB.
  - mem_wdata = wdata << 8·off.
- BEAT1 drives:
  - mem_addr = BEAT0 address + NB, wrapping mod 2^ADDR_W.
  - mem_wen = size-mask >> (NB−off).
  - mem_wdata = wdata >> 8·(NB−off).
- Loads: beat-0 rdata is captured at the end of BEAT1. In DRAIN, {rdata1, rdata0} >> 8·off is taken, truncated to size, and sign-extended (LB/LH/LW/LD) or zero-extended (LBU/LHU/LWU). The result is registered into rsp_data.
- Illegal funct3 (111; 011/110 when XLEN=32; 100–111 for stores): accepted, no mem_en, err_funct pulses the next cycle, unit stays IDLE.
- When mem_en=0: mem_wen=0; mem_addr and mem_wdata hold their last values.

## Timing
- Accept in cycle A.
- Aligned store: mem_en in A+1; req_ready high again in A+2.
- Split store: beats in A+1 and A+2; ready in A+3.
- Aligned load: beat in A+1, data in A+2; rsp_valid in A+3, coincident with req_ready=1, so back-to-back accept in A+3 is legal.
- Split load: beats in A+1 and A+2; rsp_valid in A+4.
- Error pulses occur in A+1; ready remains high.
- Reset values: req_ready=1 (visible the cycle after reset release); mem_en, mem_wen, rsp_valid, err_misalign and err_funct = 0; mem_addr, mem_wdata, rsp_data and rsp_rd = 0; state IDLE.
- Reset mid-operation: returns to IDLE at that edge and the pending access is abandoned. A split store may leave beat 0 already written. No rsp is emitted.
- req_* inputs are ignored outside IDLE.

## Configuration
- MISALIGN_SPLIT_EN defined:
  - Non-naturally-aligned accesses that fit one bus word execute in one beat.
  - Boundary-crossing accesses split as above.
- MISALIGN_SPLIT_EN undefined:
  - Any access with addr mod size ≠ 0 is rejected: no mem_en, err_misalign in A+1, no rsp.
  - The BEAT1 state is not compiled in.

## Test plan
- XLEN=32: SB addr 0x103, wdata 0xAB → one beat, mem_addr 0x100, mem_wen 4'b1000, mem_wdata[31:24]=0xAB.
- XLEN=32: LH addr 0x102, rdata 0x8001_xxxx → rsp_data 0xFFFF8001 in A+3; LHU → 0x00008001.
- XLEN=32, macro on: SW addr 0x1FE, wdata 0x11223344 → beat0 0x1FC wen 1100 data 0x3344_xxxx; beat1 0x200 wen 0011 data 0xxxxx_1122; ready in A+3.
- Macro on: LW addr 0x3, rdata0 0xDDCCBBAA, rdata1 0x44332211 → rsp_data 0x332211DD in A+4.
- Macro off: LW addr 0x2 → err_misalign in A+1, no mem_en, no rsp_valid.
- XLEN=32: funct3 011 → err_funct in A+1. Split load with rst low in A+2 → no rsp; req_ready=1 after release.
